// File: rtl/qos_pkg.sv
// Shared definitions for the QoS virtual-channel to destination path:
// word layout, default width and the arbiter FSM state encoding.
package qos_pkg;

    localparam int BW_DEFAULT = 6;
    localparam int CLASS_BIT  = BW_DEFAULT - 1;
    localparam int DEST_BIT   = BW_DEFAULT - 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_GRANT0 = 2'd1;
    localparam state_t ST_GRANT1 = 2'd2;
    localparam state_t ST_STALL  = 2'd3;

    // Destination bit position for an arbitrary word width.
    function automatic int dest_pos(input int bw);
        return bw - 2;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of VC0 grants taken while VC1 waits; raises force_vc1
// once the count reaches a non-zero starve_limit.
module arb_starve_ctr #(
    parameter int STARVE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STARVE_W-1:0] starve_limit,
    input  logic                vc0_grant,
    input  logic                vc1_grant,
    input  logic                vc1_empty,
    output logic                force_vc1
);

    logic [STARVE_W-1:0] count;
    logic [STARVE_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (vc1_empty || vc1_grant) begin
            count_next = '0;
        end else if (vc0_grant && (count != '1)) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Compare the post-update value so a grant on this cycle already counts
    // toward the next selection.
    assign force_vc1 = (starve_limit != '0) && (count_next >= starve_limit);

endmodule

// File: rtl/arbitro_vc_destino.sv
// Pops the VC0/VC1 FIFOs (VC0 priority with starvation guard) and steers each
// word to D0/D1 by its destination bit. Optional statistics: ARB_STATS_EN.
module arbitro_vc_destino
    import qos_pkg::*;
#(
    parameter int BW       = BW_DEFAULT,
    parameter int STARVE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STARVE_W-1:0] starve_limit,
    input  logic                VC0_empty,
    input  logic                VC1_empty,
    input  logic [BW-1:0]       VC0_data_out,
    input  logic [BW-1:0]       VC1_data_out,
    input  logic                D0_almost_full,
    input  logic                D1_almost_full,
    output logic                VC0_rd,
    output logic                VC1_rd,
    output logic                D0_wr,
    output logic                D1_wr,
    output logic [BW-1:0]       D_data_in,
    output logic                active_out,
    output logic                idle_out
`ifdef ARB_STATS_EN
    ,
    output logic [7:0]          grant_cnt0,
    output logic [7:0]          grant_cnt1,
    output logic                starve_evt
`endif
);

    localparam int DEST_POS = dest_pos(BW);

    state_t        state;
    state_t        state_next;
    logic          pause;
    logic          both_empty;
    logic          force_vc1;
    logic          sel_vc1;
    logic          sel_forced;
    logic          in_flight;
    logic          src_vc1;
    logic [BW-1:0] word;

    assign pause      = D0_almost_full | D1_almost_full;
    assign both_empty = VC0_empty & VC1_empty;
    assign sel_vc1    = VC0_empty | (force_vc1 & ~VC1_empty);
    assign sel_forced = force_vc1 & ~VC0_empty & ~VC1_empty;

    // The FIFO flags lag a pop by one cycle, so a granted state re-checks
    // emptiness before reading.
    assign VC0_rd = (state == ST_GRANT0) & ~VC0_empty & ~pause;
    assign VC1_rd = (state == ST_GRANT1) & ~VC1_empty & ~pause;

    always_comb begin
        state_next = state;
        case (state)
            ST_STALL: begin
                if (!pause) begin
                    if (both_empty)   state_next = ST_IDLE;
                    else if (sel_vc1) state_next = ST_GRANT1;
                    else              state_next = ST_GRANT0;
                end
            end
            default: begin
                if (both_empty)   state_next = ST_IDLE;
                else if (pause)   state_next = ST_STALL;
                else if (sel_vc1) state_next = ST_GRANT1;
                else              state_next = ST_GRANT0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    arb_starve_ctr #(
        .STARVE_W (STARVE_W)
    ) u_starve (
        .clk          (clk),
        .reset        (reset),
        .starve_limit (starve_limit),
        .vc0_grant    (VC0_rd),
        .vc1_grant    (VC1_rd),
        .vc1_empty    (VC1_empty),
        .force_vc1    (force_vc1)
    );

    assign word = src_vc1 ? VC1_data_out : VC0_data_out;

    // Read data arrives the cycle after the pop; push it on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight <= 1'b0;
            src_vc1   <= 1'b0;
            D_data_in <= '0;
            D0_wr     <= 1'b0;
            D1_wr     <= 1'b0;
        end else begin
            in_flight <= VC0_rd | VC1_rd;
            if (VC0_rd | VC1_rd) begin
                src_vc1 <= VC1_rd;
            end
            D0_wr <= 1'b0;
            D1_wr <= 1'b0;
            if (in_flight) begin
                D_data_in <= word;
                D0_wr     <= ~word[DEST_POS];
                D1_wr     <= word[DEST_POS];
            end
        end
    end

    assign active_out = VC0_rd | VC1_rd | D0_wr | D1_wr;
    assign idle_out   = both_empty & ~in_flight & ~VC0_rd & ~VC1_rd;

`ifdef ARB_STATS_EN
    logic forced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            forced     <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            forced     <= (state_next == ST_GRANT1) & sel_forced;
            grant_cnt0 <= grant_cnt0 + {7'd0, VC0_rd};
            grant_cnt1 <= grant_cnt1 + {7'd0, VC1_rd};
        end
    end

    assign starve_evt = VC1_rd & forced;
`endif

endmodule

// File: tb/tb_arbitro_vc_destino.sv
// Directed bench for arbitro_vc_destino with a behavioural model of the VC FIFOs.
module tb_arbitro_vc_destino;

    localparam int BW = 6;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] starve_limit;
    logic          VC0_empty, VC1_empty;
    logic [BW-1:0] VC0_data_out, VC1_data_out;
    logic          D0_almost_full, D1_almost_full;
    logic          VC0_rd, VC1_rd, D0_wr, D1_wr, active_out, idle_out;
    logic [BW-1:0] D_data_in;
`ifdef ARB_STATS_EN
    logic [7:0]    grant_cnt0, grant_cnt1;
    logic          starve_evt;
    logic          o_sevt;
`endif

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic          o_rd0, o_rd1, o_d0, o_d1, o_act, o_idle;
    logic [BW-1:0] o_data;

    always #5 clk = ~clk;

    arbitro_vc_destino #(.BW(BW), .STARVE_W(SW)) dut (
        .clk            (clk),
        .reset          (reset),
        .starve_limit   (starve_limit),
        .VC0_empty      (VC0_empty),
        .VC1_empty      (VC1_empty),
        .VC0_data_out   (VC0_data_out),
        .VC1_data_out   (VC1_data_out),
        .D0_almost_full (D0_almost_full),
        .D1_almost_full (D1_almost_full),
        .VC0_rd         (VC0_rd),
        .VC1_rd         (VC1_rd),
        .D0_wr          (D0_wr),
        .D1_wr          (D1_wr),
        .D_data_in      (D_data_in),
        .active_out     (active_out),
        .idle_out       (idle_out)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1),
        .starve_evt     (starve_evt)
`endif
    );

    // Sample mid-cycle, then apply the FIFO pops just after the rising edge.
    task automatic step();
        @(negedge clk);
        o_rd0  = VC0_rd;
        o_rd1  = VC1_rd;
        o_d0   = D0_wr;
        o_d1   = D1_wr;
        o_act  = active_out;
        o_idle = idle_out;
        o_data = D_data_in;
`ifdef ARB_STATS_EN
        o_sevt = starve_evt;
`endif
        @(posedge clk);
        #1;
        if (o_rd0 && q0.size() > 0) VC0_data_out = q0.pop_front();
        if (o_rd1 && q1.size() > 0) VC1_data_out = q1.pop_front();
        VC0_empty = (q0.size() == 0);
        VC1_empty = (q1.size() == 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        VC0_empty = 1'b1;
        VC1_empty = 1'b1;
        VC0_data_out = '0;
        VC1_data_out = '0;
        D0_almost_full = 1'b0;
        D1_almost_full = 1'b0;
        starve_limit = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        VC0_empty = 1'b1;
        VC1_empty = 1'b1;
        VC0_data_out = '0;
        VC1_data_out = '0;
        D0_almost_full = 1'b0;
        D1_almost_full = 1'b0;
        starve_limit = 4'd2;
        #12;
        n_checks++; if (VC0_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vc0_rd: got %b want 0", VC0_rd); end
        n_checks++; if (VC1_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vc1_rd: got %b want 0", VC1_rd); end
        n_checks++; if (D0_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_d0_wr: got %b want 0", D0_wr); end
        n_checks++; if (D1_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_d1_wr: got %b want 0", D1_wr); end
        n_checks++; if (D_data_in !== 6'h00) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 00", D_data_in); end
        n_checks++; if (active_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active: got %b want 0", active_out); end
        n_checks++; if (idle_out !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_idle: got %b want 1", idle_out); end
        do_reset();
    endtask

    task automatic test_vc0_only();
        logic [6:0] e_rd0  = 7'b0001110;
        logic [6:0] e_d0   = 7'b0101000;
        logic [6:0] e_d1   = 7'b0010000;
        logic [6:0] e_act  = 7'b0111110;
        logic [6:0] e_idle = 7'b1100000;
        logic [5:0] e_vec, g_vec;
        do_reset();
        q0.push_back(6'h05);
        q0.push_back(6'h13);
        q0.push_back(6'h26);
        VC0_empty = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            e_vec = {e_rd0[k], 1'b0, e_d0[k], e_d1[k], e_act[k], e_idle[k]};
            g_vec = {o_rd0, o_rd1, o_d0, o_d1, o_act, o_idle};
            n_checks++;
            if (g_vec !== e_vec) begin
                n_fail++;
                $display("[TB] FAIL vc0_only cycle %0d {rd0,rd1,d0,d1,act,idle}: got %b want %b", k, g_vec, e_vec);
            end
            if (k >= 3 && k <= 5) begin
                n_checks++;
                if (o_data !== ((k == 3) ? 6'h05 : (k == 4) ? 6'h13 : 6'h26)) begin
                    n_fail++;
                    $display("[TB] FAIL vc0_only data cycle %0d: got %h", k, o_data);
                end
            end
        end
    endtask

    task automatic test_starvation();
        logic [19:0] e_rd0 = 20'h006EE;
        logic [19:0] e_rd1 = 20'h3F110;
        logic [7:0]  e_push;
        do_reset();
        starve_limit = 4'd3;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(6'(i));
            q1.push_back(6'(8'h30 + i));
        end
        VC0_empty = 1'b0;
        VC1_empty = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++;
            if ({o_rd0, o_rd1} !== {e_rd0[k], e_rd1[k]}) begin
                n_fail++;
                $display("[TB] FAIL starve_order cycle %0d {rd0,rd1}: got %b%b want %b%b", k, o_rd0, o_rd1, e_rd0[k], e_rd1[k]);
            end
            if (k == 3 || k == 5 || k == 6 || k == 14) begin
                e_push = (k == 3) ? 8'b10_000000 : (k == 5) ? 8'b10_000010 :
                         (k == 6) ? 8'b01_110000 : 8'b01_110010;
                n_checks++;
                if ({o_d0, o_d1, o_data} !== e_push) begin
                    n_fail++;
                    $display("[TB] FAIL starve_push cycle %0d {d0,d1,data}: got %b want %b", k, {o_d0, o_d1, o_data}, e_push);
                end
            end
`ifdef ARB_STATS_EN
            n_checks++;
            if (o_sevt !== ((k == 4) || (k == 8))) begin
                n_fail++;
                $display("[TB] FAIL starve_evt cycle %0d: got %b", k, o_sevt);
            end
`endif
        end
`ifdef ARB_STATS_EN
        n_checks++; if (grant_cnt0 !== 8'd8) begin n_fail++; $display("[TB] FAIL grant_cnt0: got %0d want 8", grant_cnt0); end
        n_checks++; if (grant_cnt1 !== 8'd8) begin n_fail++; $display("[TB] FAIL grant_cnt1: got %0d want 8", grant_cnt1); end
`endif
    endtask

    task automatic test_no_guard();
        logic [11:0] e_rd0 = 12'h01E;
        logic [11:0] e_rd1 = 12'h3C0;
        do_reset();
        starve_limit = 4'd0;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(6'(8'h08 + i));
            q1.push_back(6'(8'h38 + i));
        end
        VC0_empty = 1'b0;
        VC1_empty = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if ({o_rd0, o_rd1} !== {e_rd0[k], e_rd1[k]}) begin
                n_fail++;
                $display("[TB] FAIL no_guard cycle %0d {rd0,rd1}: got %b%b want %b%b", k, o_rd0, o_rd1, e_rd0[k], e_rd1[k]);
            end
        end
    endtask

    task automatic test_pause();
        logic [10:0] e_rd0 = 11'h186;
        logic [10:0] e_d0  = 11'h618;
        logic [3:0]  e_vec, g_vec;
        do_reset();
        for (int i = 1; i <= 4; i++) q0.push_back(6'(i));
        VC0_empty = 1'b0;
        for (int k = 0; k < 11; k++) begin
            step();
            D1_almost_full = (k >= 2 && k <= 4);
            e_vec = {e_rd0[k], 1'b0, e_d0[k], 1'b0};
            g_vec = {o_rd0, o_rd1, o_d0, o_d1};
            n_checks++;
            if (g_vec !== e_vec) begin
                n_fail++;
                $display("[TB] FAIL pause cycle %0d {rd0,rd1,d0,d1}: got %b want %b", k, g_vec, e_vec);
            end
            if (k == 3 || k == 4 || k == 9 || k == 10) begin
                n_checks++;
                if (o_data !== ((k == 3) ? 6'h01 : (k == 4) ? 6'h02 : (k == 9) ? 6'h03 : 6'h04)) begin
                    n_fail++;
                    $display("[TB] FAIL pause data cycle %0d: got %h", k, o_data);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        starve_limit = 4'd0;
        q0.push_back(6'h15);
        q1.push_back(6'h31);
        q1.push_back(6'h32);
        VC0_empty = 1'b0;
        VC1_empty = 1'b0;
        step();
        step();
        n_checks++; if (o_rd0 !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pop: got %b want 1", o_rd0); end
        n_checks++; if (dut.u_starve.count !== 4'd1) begin n_fail++; $display("[TB] FAIL mid_count_pre: got %0d want 1", dut.u_starve.count); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if ({VC0_rd, VC1_rd, D0_wr, D1_wr} !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_rst_ctrl: got %b want 0000", {VC0_rd, VC1_rd, D0_wr, D1_wr}); end
        n_checks++; if (active_out !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_active: got %b want 0", active_out); end
        n_checks++; if (D_data_in !== 6'h00) begin n_fail++; $display("[TB] FAIL mid_rst_data: got %h want 00", D_data_in); end
        n_checks++; if (dut.u_starve.count !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_rst_count: got %0d want 0", dut.u_starve.count); end
        #1;
        reset = 1'b0;
        for (int k = 2; k < 5; k++) begin
            step();
            n_checks++;
            if ({o_d0, o_d1} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL mid_no_push cycle %0d: got %b want 00", k, {o_d0, o_d1});
            end
            if (k == 3) begin
                n_checks++;
                if ({o_rd0, o_rd1} !== 2'b01) begin
                    n_fail++;
                    $display("[TB] FAIL mid_resume: got %b want 01", {o_rd0, o_rd1});
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_vc0_only();
        test_starvation();
        test_no_guard();
        test_pause();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
